// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel write-back path: frame geometry defaults,
// coordinate tag layout and the packed 24-bit colour word.
package pixel_pkg;

  localparam int H_ACTIVE_DEF = 1280;
  localparam int V_ACTIVE_DEF = 720;
  localparam int X_W          = 11;
  localparam int Y_W          = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pix_tag_t;

endpackage

// File: rtl/float_to_u8.sv
// Combinational IEEE-754 single to 8-bit unsigned colour conversion.
// Negative values and NaN map to 0, values >= 1.0 (and +inf) saturate to 255,
// otherwise the result is floor(v*256).
module float_to_u8 (
  input  logic [31:0] i_f,
  output logic [7:0]  o_u8
);

  function automatic logic [7:0] sat_u8(input logic [31:0] f);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [23:0] sig;
    logic [4:0]  sh;
    s   = f[31];
    e   = f[30:23];
    m   = f[22:0];
    sig = {1'b1, m};
    // For e in 119..126 the shift 23-(e-119) = 142-e lies in 16..23.
    sh  = 5'(8'd142 - e);
    if (s)
      sat_u8 = 8'h00;
    else if (e == 8'hFF && m != 23'd0)
      sat_u8 = 8'h00;
    else if (e >= 8'd127)
      sat_u8 = 8'hFF;
    else if (e < 8'd119)
      sat_u8 = 8'h00;
    else
      sat_u8 = 8'(sig >> sh);
  endfunction

  assign o_u8 = sat_u8(i_f);

endmodule

// File: rtl/pixel_writeback.sv
// Output end of the ray-casting pipeline: pairs in-order float RGB results
// with queued (x, y) tags, converts to 8-bit channels and writes the packed
// colour into the frame buffer two cycles after the result strobe.
module pixel_writeback
  import pixel_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int TAG_DEPTH = 64,
  parameter int ADDR_W    = 20
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         tag_valid_in,
  input  logic [X_W-1:0]               tag_x_in,
  input  logic [Y_W-1:0]               tag_y_in,
  output logic                         tag_ready_out,
  input  logic [31:0]                  r_in,
  input  logic [31:0]                  g_in,
  input  logic [31:0]                  b_in,
  input  logic                         rgb_valid_in,
  output logic [ADDR_W-1:0]            fb_addr_out,
  output logic [23:0]                  fb_data_out,
  output logic                         fb_we_out,
  output logic                         frame_done_out,
  output logic                         orphan_err_out,
  output logic [$clog2(TAG_DEPTH):0]   tag_count_out
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  pix_tag_t           r_mem [TAG_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  pix_tag_t           w_head;
  logic               w_in_frame;
  logic [7:0]         w_r8;
  logic [7:0]         w_g8;
  logic [7:0]         w_b8;

  logic               r_vld_p1;
  pix_tag_t           r_tag_p1;
  rgb24_t             r_rgb_p1;
  logic               r_orphan;
  logic [ADDR_W-1:0]  w_addr_p1;
  logic               w_last_p1;

  logic               r_we_p2;
  logic               r_done_p2;
  logic [ADDR_W-1:0]  r_addr_p2;
  rgb24_t             r_data_p2;

  assign w_full        = (r_count == CNT_W'(TAG_DEPTH));
  assign w_empty       = (r_count == '0);
  // Held low while reset is asserted so the issuer cannot push into a FIFO
  // that is being cleared.
  assign tag_ready_out = !rst_in && !w_full;
  assign w_push        = tag_valid_in && tag_ready_out;
  // Pop only against tags already stored; a tag pushed this cycle is not
  // visible to a result arriving in the same cycle.
  assign w_pop         = rgb_valid_in && !w_empty && !rst_in;
  assign w_head        = r_mem[r_rd_ptr];
  assign w_in_frame    = (int'(w_head.x) < H_ACTIVE) && (int'(w_head.y) < V_ACTIVE);

  float_to_u8 u_conv_r (.i_f(r_in), .o_u8(w_r8));
  float_to_u8 u_conv_g (.i_f(g_in), .o_u8(w_g8));
  float_to_u8 u_conv_b (.i_f(b_in), .o_u8(w_b8));

  // Tag FIFO pointers and occupancy.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - CNT_W'(1);
    end
  end

  // Tag FIFO storage.
  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr_ptr] <= '{x: tag_x_in, y: tag_y_in};
  end

  // ---- stage p1: converted channels and popped tag ----
  always_ff @(posedge clk_in) begin
    if (w_pop) begin
      r_tag_p1 <= w_head;
      r_rgb_p1 <= '{r: w_r8, g: w_g8, b: w_b8};
    end
  end

  // Stage p1 valid (out-of-frame tags are consumed but never written) and
  // the sticky orphan flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_vld_p1 <= 1'b0;
      r_orphan <= 1'b0;
    end else begin
      r_vld_p1 <= w_pop && w_in_frame;
      r_orphan <= r_orphan || (rgb_valid_in && w_empty);
    end
  end

  assign w_addr_p1 = ADDR_W'(r_tag_p1.y) * ADDR_W'(H_ACTIVE) + ADDR_W'(r_tag_p1.x);
  assign w_last_p1 = (int'(r_tag_p1.x) == H_ACTIVE - 1) &&
                     (int'(r_tag_p1.y) == V_ACTIVE - 1);

  // ---- stage p2: frame-buffer write port ----
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_we_p2   <= 1'b0;
      r_done_p2 <= 1'b0;
      r_addr_p2 <= '0;
      r_data_p2 <= '0;
    end else begin
      r_we_p2   <= r_vld_p1;
      r_done_p2 <= r_vld_p1 && w_last_p1;
      if (r_vld_p1) begin
        r_addr_p2 <= w_addr_p1;
        r_data_p2 <= r_rgb_p1;
      end
    end
  end

  assign fb_we_out      = r_we_p2;
  assign frame_done_out = r_done_p2;
  assign fb_addr_out    = r_addr_p2;
  assign fb_data_out    = r_data_p2;
  assign orphan_err_out = r_orphan;
  assign tag_count_out  = r_count;

endmodule

// File: doc/pixel_writeback.md
# pixel_writeback

Output end of the ray-casting pixel pipeline. Accepts in-order float32 RGB results from `get_pixel_color` and converts each channel to 8-bit unsigned. Pairs each result with the (x, y) coordinate tag queued when its ray was issued, then writes the packed 24-bit colour into the frame-buffer BRAM write port. Also reports frame completion and tag/result mismatches.

## Interface
Parameters:
- `H_ACTIVE`, 1280, pixels per line; also the address stride.
- `V_ACTIVE`, 720, lines per frame.
- `TAG_DEPTH`, 64, tag FIFO entries; power of two, at least the `get_pixel_color` latency plus 2.
- `ADDR_W`, 20, frame-buffer address width.

Ports:
- `clk_in` in 1: system clock.
- `rst_in` in 1: synchronous, active-high reset.
- `tag_valid_in` in 1: issuer pushes a coordinate tag.
- `tag_x_in` in 11: pixel x.
- `tag_y_in` in 10: pixel y.
- `tag_ready_out` out 1: FIFO not full; a push occurs only when `tag_valid_in && tag_ready_out`.
- `r_in`, `g_in`, `b_in` in 32 each: IEEE-754 single colour channels.
- `rgb_valid_in` in 1: result strobe, one pixel per cycle.
- `fb_addr_out` out ADDR_W: `y*H_ACTIVE + x`.
- `fb_data_out` out 24: `{r8, g8, b8}`.
- `fb_we_out` out 1: single-cycle write enable.
- `frame_done_out` out 1: one-cycle pulse with the write of pixel (H_ACTIVE-1, V_ACTIVE-1).
- `orphan_err_out` out 1: sticky; set when a result arrives while the FIFO is empty.
- `tag_count_out` out $clog2(TAG_DEPTH)+1: current FIFO occupancy.

## Operation
**Tag FIFO**
- Circular buffer with read and write pointers plus a count; pointers wrap modulo TAG_DEPTH.
- A pop occurs on `rgb_valid_in` when count is greater than 0 at the start of the cycle. There is no same-cycle bypass.
- Simultaneous push and pop leaves the count unchanged.
- `tag_ready_out` = (count != TAG_DEPTH). A push presented while full is dropped; avoiding this is the issuer's responsibility.

**Float-to-u8 conversion (per channel)**

s = sign, e = exponent, m = mantissa.
- s=1 (including -0.0 and negative NaN): result is 0.
- e=255 and m≠0 (NaN): result is 0.
- e ≥ 127 (value ≥ 1.0, including +inf): result is 255.
- e < 119 (value < 1/256): result is 0.
- Otherwise: result = `{1'b1, m} >> (23 - (e-119))`. This equals floor(v·256), which is ≤ 255 within this range.

**Write path**
- Result strobe with a tag present: convert and write to `y*H_ACTIVE + x`.
- Result strobe with the FIFO empty: no write, and `orphan_err_out` is set and held until reset.
- Tags outside the frame (x ≥ H_ACTIVE or y ≥ V_ACTIVE) are popped but not written.

## Timing
- Reset: all outputs are 0, the FIFO is empty, pointers are 0, and `tag_ready_out` is 1 in the cycle after reset deasserts. During reset `tag_ready_out` is 0 and no writes occur.
- Stage 1 (cycle of `rgb_valid_in` +1): register the converted channels, the popped tag, and a valid bit.
- Stage 2 (+2): register the address (multiply-add) and data, and assert `fb_we_out`. Total latency from `rgb_valid_in` to `fb_we_out` is exactly 2 cycles.
- Throughput is one pixel per cycle, with no stalls on the result side.
- `frame_done_out` is coincident with the corresponding `fb_we_out`.
- `orphan_err_out` rises 1 cycle after the offending strobe.
- `tag_count_out` and `tag_ready_out` update 1 cycle after a push or pop.
- Reset mid-operation: pipeline valid bits clear, no write occurs in the cycle after reset is sampled, and in-flight tags are discarded.

## Structure
- Shared package `pixel_pkg`: `H_ACTIVE`/`V_ACTIVE` defaults and the `rgb24_t` packed struct {r, g, b}.
- One sub-module `float_to_u8` (combinational, instantiated 3×), covering the sign/NaN/clamp/shift rules above.
- The FIFO is inline.

## Test plan
- **Single pixel:** push tag (3, 2), then strobe r=0x3F800000 (1.0), g=0x3F000000 (0.5), b=0x00000000 → 2 cycles later `fb_we_out`=1, addr=2563, data=0xFF8000.
- **Conversion corners:** strobes with 0xBF800000, 0x7FC00000, 0x7F800000, 0x3B800000 (1/256) and 0x3F7FFFFF → channel bytes 0x00, 0x00, 0xFF, 0x01, 0xFF.
- **Full FIFO:** push 64 tags → `tag_ready_out`=0 and count=64. A 65th push is dropped. Then 64 strobes → 64 writes in push order, addresses matching the tags.
- **Simultaneous push/pop:** at count=5, push and strobe in the same cycle → count stays 5, and the write uses the oldest tag.
- **Orphan:** strobe with the FIFO empty → no write, and `orphan_err_out`=1 until `rst_in`.
- **Frame end and reset:** tag (1279, 719) → addr 921599 and `frame_done_out` pulse. Separately, assert reset 1 cycle after a strobe → no write, outputs 0, count 0.
